// File: rtl/audio_stream_ctrl.sv
// Streams audio samples from word-wide flash: one-word current buffer plus one-word prefetch buffer, one lane per sample_tick.
// Optional macro VOLUME_SCALE_EN adds a 3-bit volume input that arithmetically shifts each emitted lane.
module audio_stream_ctrl #(
    parameter int ADDR_W   = 23,
    parameter int WORD_W   = 32,
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic                loop_en,
    input  logic                sample_tick,
`ifdef VOLUME_SCALE_EN
    input  logic [2:0]          volume,
`endif
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                mem_valid,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                busy,
    output logic                finish,
    output logic                underrun
);
    localparam int LANES = WORD_W / SAMPLE_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                loop_q, loop_d;
    logic [WORD_W-1:0]   cur_buf_q, cur_buf_d;
    logic [WORD_W-1:0]   nxt_buf_q, nxt_buf_d;
    logic                cur_valid_q, cur_valid_d;
    logic                nxt_valid_q, nxt_valid_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic                rd_pend_q, rd_pend_d;
    logic                stale_q, stale_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                busy_q, busy_d;
    logic                finish_q, finish_d;
    logic                underrun_q, underrun_d;

    logic                rd_take_s;
    logic                tick_s;
    logic                at_end_s;
    logic                need_next_s;
    logic                play_end_s;
    logic [ADDR_W-1:0]   next_addr_s;
    logic [SAMPLE_W-1:0] lane_s;
    logic [SAMPLE_W-1:0] lane_out_s;

    // Memory returns in order, so a read abandoned by a restart is the next mem_valid and gets dropped via stale_q.
    assign rd_take_s   = rd_pend_q & ~mem_rd_q & mem_valid & ~stale_q;
    assign tick_s      = sample_tick & ~start;
    assign at_end_s    = (cur_addr_q == end_q);
    assign need_next_s = ~at_end_s | loop_q;
    assign next_addr_s = at_end_s ? start_q : (cur_addr_q + ADDR_W'(1));
    assign play_end_s  = tick_s & cur_valid_q & (idx_q == LAST_IDX) & at_end_s & ~loop_q;
    assign lane_s      = SAMPLE_W'(cur_buf_q >> (idx_q * SAMPLE_W));

`ifdef VOLUME_SCALE_EN
    assign lane_out_s = SAMPLE_W'($signed(lane_s) >>> volume);
`else
    assign lane_out_s = lane_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start pulse always restarts from FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
                else       state_d = S_IDLE;
            end
            S_FETCH: begin
                if (start)               state_d = S_FETCH;
                else if (start_q > end_q) state_d = S_DONE;
                else                     state_d = S_WAIT;
            end
            S_WAIT: begin
                if (start)          state_d = S_FETCH;
                else if (rd_take_s) state_d = S_PLAY;
                else                state_d = S_WAIT;
            end
            S_PLAY: begin
                if (start)           state_d = S_FETCH;
                else if (play_end_s) state_d = S_DONE;
                else                 state_d = S_PLAY;
            end
            S_DONE: begin
                if (start) state_d = S_FETCH;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next-state: buffers, read handshake, sample emission.
    always_comb begin
        start_d        = start_q;
        end_d          = end_q;
        loop_d         = loop_q;
        cur_buf_d      = cur_buf_q;
        nxt_buf_d      = nxt_buf_q;
        cur_valid_d    = cur_valid_q;
        nxt_valid_d    = nxt_valid_q;
        idx_d          = idx_q;
        cur_addr_d     = cur_addr_q;
        rd_pend_d      = rd_pend_q & ~rd_take_s;
        stale_d        = stale_q & ~mem_valid;
        mem_addr_d     = mem_addr_q;
        mem_rd_d       = 1'b0;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        underrun_d     = 1'b0;
        busy_d         = (state_d != S_IDLE);
        finish_d       = (state_d == S_DONE);

        if (start) begin
            start_d     = start_addr;
            end_d       = end_addr;
            loop_d      = loop_en;
            cur_valid_d = 1'b0;
            nxt_valid_d = 1'b0;
            idx_d       = '0;
            stale_d     = stale_d | (rd_pend_q & ~rd_take_s);
            if (start_addr <= end_addr) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = start_addr;
                rd_pend_d  = 1'b1;
            end else begin
                rd_pend_d  = 1'b0;
            end
        end else if (state_q == S_WAIT) begin
            if (rd_take_s) begin
                cur_buf_d   = mem_rdata;
                cur_valid_d = 1'b1;
                idx_d       = '0;
                cur_addr_d  = mem_addr_q;
            end else begin
                cur_valid_d = cur_valid_q;
            end
        end else if (state_q == S_PLAY) begin
            if (tick_s && cur_valid_q) begin
                sample_d       = lane_out_s;
                sample_valid_d = 1'b1;
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + IDX_W'(1);
                end else if (nxt_valid_q) begin
                    cur_buf_d   = nxt_buf_q;
                    nxt_valid_d = 1'b0;
                    cur_addr_d  = next_addr_s;
                    idx_d       = '0;
                end else begin
                    cur_valid_d = 1'b0;
                end
            end else if (tick_s) begin
                sample_d       = '0;
                sample_valid_d = 1'b1;
                underrun_d     = 1'b1;
            end else begin
                sample_valid_d = 1'b0;
            end

            // A word arriving while the current buffer is drained goes straight into play.
            if (rd_take_s && cur_valid_d) begin
                nxt_buf_d   = mem_rdata;
                nxt_valid_d = 1'b1;
            end else if (rd_take_s) begin
                cur_buf_d   = mem_rdata;
                cur_valid_d = 1'b1;
                idx_d       = '0;
                cur_addr_d  = mem_addr_q;
            end else begin
                nxt_valid_d = nxt_valid_d;
            end

            if (!nxt_valid_q && !rd_pend_q && !stale_q && need_next_s) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = next_addr_s;
                rd_pend_d  = 1'b1;
            end else begin
                mem_rd_d   = 1'b0;
            end
        end else begin
            cur_valid_d = cur_valid_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q        <= '0;
            end_q          <= '0;
            loop_q         <= 1'b0;
            cur_buf_q      <= '0;
            nxt_buf_q      <= '0;
            cur_valid_q    <= 1'b0;
            nxt_valid_q    <= 1'b0;
            idx_q          <= '0;
            cur_addr_q     <= '0;
            rd_pend_q      <= 1'b0;
            stale_q        <= 1'b0;
            mem_addr_q     <= '0;
            mem_rd_q       <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            finish_q       <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            start_q        <= start_d;
            end_q          <= end_d;
            loop_q         <= loop_d;
            cur_buf_q      <= cur_buf_d;
            nxt_buf_q      <= nxt_buf_d;
            cur_valid_q    <= cur_valid_d;
            nxt_valid_q    <= nxt_valid_d;
            idx_q          <= idx_d;
            cur_addr_q     <= cur_addr_d;
            rd_pend_q      <= rd_pend_d;
            stale_q        <= stale_d;
            mem_addr_q     <= mem_addr_d;
            mem_rd_q       <= mem_rd_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            finish_q       <= finish_d;
            underrun_q     <= underrun_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign finish       = finish_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl: memory model with programmable latency, event logs, immediate-assertion checks.
module tb_audio_stream_ctrl;
    localparam int ADDR_W   = 23;
    localparam int WORD_W   = 32;
    localparam int SAMPLE_W = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   start_addr = '0;
    logic [ADDR_W-1:0]   end_addr = '0;
    logic                loop_en = 1'b0;
    logic                sample_tick = 1'b0;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic [WORD_W-1:0]   mem_rdata = '0;
    logic                mem_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                busy;
    logic                finish;
    logic                underrun;
`ifdef VOLUME_SCALE_EN
    logic [2:0]          volume = 3'd0;
`endif

    audio_stream_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .loop_en(loop_en), .sample_tick(sample_tick),
`ifdef VOLUME_SCALE_EN
        .volume(volume),
`endif
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .sample(sample), .sample_valid(sample_valid), .busy(busy), .finish(finish),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Flash model: answers each read `lat` cycles later; `inj` forces one unsolicited mem_valid.
    int lat = 1;
    int mcnt = 0;
    logic inj = 1'b0;
    logic [ADDR_W-1:0] maddr = '0;

    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
        case (a)
            23'd625: word_at = 32'h0403_0201;
            23'd626: word_at = 32'h0807_0605;
            23'd627: word_at = 32'h0C0B_0A09;
            23'd628: word_at = 32'h0000_0080;
            default: word_at = 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        mem_valid = 1'b0;
        if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                mem_valid = 1'b1;
                mem_rdata = word_at(maddr);
            end
        end
        if (inj) begin
            mem_valid = 1'b1;
            mem_rdata = 32'hA5A5_A5A5;
        end
        if (mem_rd) begin
            mcnt  = lat;
            maddr = mem_addr;
        end
    end

    // Event logs written only here; the stimulus block reads them via snapshot indices.
    logic [7:0] smp_log[$];
    bit         und_log[$];
    int fin_cnt = 0;
    int rd_cnt  = 0;
    int und_cnt = 0;

    always @(negedge clk) begin
        if (sample_valid) begin
            smp_log.push_back(sample);
            und_log.push_back(underrun);
        end
        if (finish)   fin_cnt = fin_cnt + 1;
        if (mem_rd)   rd_cnt  = rd_cnt + 1;
        if (underrun) und_cnt = und_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                            input logic lp, input logic tk);
        start_addr  = sa;
        end_addr    = ea;
        loop_en     = lp;
        start       = 1'b1;
        sample_tick = tk;
        @(negedge clk);
        start       = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            cyc(period - 1);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sample"},   32'(sample), 32'h0);
        chk({tag, "_svalid"},   32'(sample_valid), 32'h0);
        chk({tag, "_busy"},     32'(busy), 32'h0);
        chk({tag, "_finish"},   32'(finish), 32'h0);
        chk({tag, "_underrun"}, 32'(underrun), 32'h0);
        chk({tag, "_mem_rd"},   32'(mem_rd), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    endtask

    initial begin
        int b, f0, r0, u0, expv, und_n;

        // Reset state
        cyc(3);
        chk_idle_outputs("reset");
        reset = 1'b0;
        cyc(1);

        // Two-word one-shot playback
        b = smp_log.size(); f0 = fin_cnt; r0 = rd_cnt; u0 = und_cnt;
        do_start(23'd625, 23'd626, 1'b0, 1'b0);
        cyc(5);
        ticks(10, 10);
        chk("oneshot_count", 32'(smp_log.size() - b), 32'd8);
        for (int i = 0; i < 8; i++) chk("oneshot_sample", 32'(smp_log[b + i]), 32'(i + 1));
        chk("oneshot_finish", 32'(fin_cnt - f0), 32'd1);
        chk("oneshot_reads", 32'(rd_cnt - r0), 32'd2);
        chk("oneshot_underrun", 32'(und_cnt - u0), 32'd0);
        chk("oneshot_busy", 32'(busy), 32'd0);
        chk("oneshot_hold", 32'(sample), 32'd8);

        // Looping playback with one unsolicited mem_valid in the middle
        b = smp_log.size(); f0 = fin_cnt; u0 = und_cnt;
        do_start(23'd625, 23'd626, 1'b1, 1'b0);
        cyc(5);
        ticks(10, 10);
        inj = 1'b1;
        cyc(1);
        inj = 1'b0;
        ticks(10, 10);
        chk("loop_count", 32'(smp_log.size() - b), 32'd20);
        for (int i = 0; i < 20; i++) chk("loop_sample", 32'(smp_log[b + i]), 32'((i % 8) + 1));
        chk("loop_finish", 32'(fin_cnt - f0), 32'd0);
        chk("loop_underrun", 32'(und_cnt - u0), 32'd0);
        chk("loop_busy", 32'(busy), 32'd1);

        // Reset in the middle of playback
        reset = 1'b1;
        cyc(1);
        chk_idle_outputs("midreset");
        reset = 1'b0;
        cyc(2);

        // Slow memory: underruns emit zero, then playback resumes without skipping
        lat = 40;
        b = smp_log.size(); f0 = fin_cnt; u0 = und_cnt;
        do_start(23'd625, 23'd626, 1'b0, 1'b0);
        ticks(120, 2);
        expv = 1; und_n = 0;
        chk("slow_first_not_underrun", 32'(und_log[b]), 32'd0);
        for (int i = b; i < smp_log.size(); i++) begin
            if (und_log[i]) begin
                chk("slow_underrun_zero", 32'(smp_log[i]), 32'd0);
                und_n = und_n + 1;
            end else begin
                chk("slow_sample", 32'(smp_log[i]), 32'(expv));
                expv = expv + 1;
            end
        end
        chk("slow_all_samples", 32'(expv), 32'd9);
        chk("slow_underrun_seen", 32'(und_n > 0), 32'd1);
        chk("slow_underrun_pulses", 32'(und_cnt - u0), 32'(und_n));
        chk("slow_finish", 32'(fin_cnt - f0), 32'd1);
        chk("slow_busy", 32'(busy), 32'd0);
        lat = 1;
        cyc(2);

        // Empty range: no read, finish two cycles after start
        r0 = rd_cnt; f0 = fin_cnt;
        do_start(23'd627, 23'd626, 1'b0, 1'b0);
        chk("empty_finish_c1", 32'(finish), 32'd0);
        chk("empty_busy_c1", 32'(busy), 32'd1);
        cyc(1);
        chk("empty_finish_c2", 32'(finish), 32'd1);
        cyc(1);
        chk("empty_finish_c3", 32'(finish), 32'd0);
        chk("empty_busy_c3", 32'(busy), 32'd0);
        chk("empty_reads", 32'(rd_cnt - r0), 32'd0);
        chk("empty_finish_once", 32'(fin_cnt - f0), 32'd1);

        // Restart mid-word, with a tick in the same cycle as start
        f0 = fin_cnt;
        do_start(23'd625, 23'd626, 1'b0, 1'b0);
        cyc(5);
        ticks(6, 10);
        b = smp_log.size();
        do_start(23'd627, 23'd627, 1'b0, 1'b1);
        cyc(5);
        ticks(6, 10);
        chk("restart_count", 32'(smp_log.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) chk("restart_sample", 32'(smp_log[b + i]), 32'(i + 9));
        chk("restart_finish", 32'(fin_cnt - f0), 32'd1);

        // Single word looping: one read per four ticks
        b = smp_log.size(); r0 = rd_cnt; u0 = und_cnt;
        do_start(23'd627, 23'd627, 1'b1, 1'b0);
        cyc(5);
        ticks(12, 10);
        chk("single_count", 32'(smp_log.size() - b), 32'd12);
        for (int i = 0; i < 12; i++) chk("single_sample", 32'(smp_log[b + i]), 32'((i % 4) + 9));
        chk("single_reads", 32'(rd_cnt - r0), 32'd5);
        chk("single_underrun", 32'(und_cnt - u0), 32'd0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);

`ifdef VOLUME_SCALE_EN
        // Volume shift is arithmetic on the signed lane
        volume = 3'd1;
        do_start(23'd628, 23'd628, 1'b0, 1'b0);
        cyc(5);
        ticks(1, 10);
        chk("volume_sample", 32'(sample), 32'h0000_00C0);
        reset = 1'b1;
        cyc(1);
        chk_idle_outputs("volreset");
        reset = 1'b0;
        volume = 3'd0;
        cyc(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
